// File: rtl/boot_loader_ctrl_pkg.sv
// Shared definitions for the boot loader: state encoding, widths and
// default flash layout / terminator values.
package boot_loader_ctrl_pkg;

    localparam int unsigned FLASH_W    = 24;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned MEM_AW     = 14;
    localparam int unsigned LEN_W      = 15;
    localparam int unsigned BANK_WORDS = 16384;

    localparam logic [FLASH_W-1:0] FLASH_ADDR0_DEF = 24'h030000;
    localparam logic [FLASH_W-1:0] FLASH_ADDR1_DEF = 24'h050000;
    localparam logic [WORD_W-1:0]  TERM_WORD_DEF   = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_LOAD0   = 3'd0,
        ST_GAP     = 3'd1,
        ST_LOAD1   = 3'd2,
        ST_WAIT_IP = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } state_e;

    // True in the two states where flash words are accepted.
    function automatic logic is_load(input state_e s);
        return (s == ST_LOAD0) || (s == ST_LOAD1);
    endfunction

endpackage

// File: rtl/boot_loader_ctrl_if.sv
// Fetcher / SPRAM / SoC-control bundle of the boot loader.
interface boot_loader_ctrl_if;
    import boot_loader_ctrl_pkg::*;

    logic                word_valid_i;
    logic [WORD_W-1:0]   word_data_i;
    logic                ip_done_i;
    logic                fill_o;
    logic                fetch_rst_o;
    logic [FLASH_W-1:0]  flash_addr_o;
    logic [MEM_AW-1:0]   mem_addr_o;
    logic [WORD_W-1:0]   mem_data_o;
    logic                mem_we0_o;
    logic                mem_we1_o;
    logic                soc_rstn_o;
    logic                busy_o;
    logic                error_o;
    logic [LEN_W-1:0]    len0_o;
    logic [LEN_W-1:0]    len1_o;

    modport slave (
        input  word_valid_i, word_data_i, ip_done_i,
        output fill_o, fetch_rst_o, flash_addr_o, mem_addr_o, mem_data_o,
               mem_we0_o, mem_we1_o, soc_rstn_o, busy_o, error_o, len0_o, len1_o
    );

    modport master (
        output word_valid_i, word_data_i, ip_done_i,
        input  fill_o, fetch_rst_o, flash_addr_o, mem_addr_o, mem_data_o,
               mem_we0_o, mem_we1_o, soc_rstn_o, busy_o, error_o, len0_o, len1_o
    );
endinterface

// File: rtl/boot_timeout_cnt.sv
// Down-counting watchdog: reloads on load_i, counts while en_i, and flags
// expire_o in the cycle that completes CYCLES idle cycles.
module boot_timeout_cnt #(
    parameter int unsigned CYCLES = 1048576
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int unsigned W      = $clog2(CYCLES + 1);
    localparam logic [W-1:0] RELOAD = W'(CYCLES);
    localparam logic [W-1:0] ONE    = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next remaining-cycle count and expiry decode.
    always_comb begin
        cnt_d    = cnt_q;
        expire_o = 1'b0;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (en_i) begin
            if (cnt_q <= ONE) begin
                expire_o = 1'b1;
                cnt_d    = RELOAD;
            end else begin
                cnt_d = cnt_q - ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Remaining-cycle register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/boot_loader_ctrl.sv
// Copies two flash images into the system0/system1 SPRAMs, waits for the
// hard IP, then releases the SoC reset. Any overflow or stall is sticky.
module boot_loader_ctrl
    import boot_loader_ctrl_pkg::*;
#(
    parameter logic [FLASH_W-1:0] FLASH_ADDR0    = FLASH_ADDR0_DEF,
    parameter logic [FLASH_W-1:0] FLASH_ADDR1    = FLASH_ADDR1_DEF,
    parameter logic [WORD_W-1:0]  TERM_WORD      = TERM_WORD_DEF,
    parameter int unsigned        GAP_CYCLES     = 12,
    parameter int unsigned        TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk_i,
    input  logic              rst_i,
    boot_loader_ctrl_if.slave bus
);
    localparam int unsigned       GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
    localparam logic [LEN_W-1:0]  BANK_FULL = LEN_W'(BANK_WORDS);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [LEN_W-1:0]    len0_q, len0_d, len1_q, len1_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_data_q, mem_data_d;
    logic                we0_q, we0_d, we1_q, we1_d;
    logic                fill_q, fill_d, frst_q, frst_d;
    logic                soc_q, soc_d, busy_q, busy_d, err_q, err_d;
    logic [FLASH_W-1:0]  flash_q, flash_d;
    logic                in_load_s, tmo_load_s, expire_s;

    assign in_load_s  = is_load(state_q);
    assign tmo_load_s = bus.word_valid_i || !in_load_s;

    boot_timeout_cnt #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (tmo_load_s),
        .en_i     (in_load_s),
        .expire_o (expire_s)
    );

    // Next state, bank write decision and output decode of the next state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = '0;
        len0_d     = len0_q;
        len1_d     = len1_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        we0_d      = 1'b0;
        we1_d      = 1'b0;
        case (state_q)
            ST_LOAD0, ST_LOAD1: begin
                if (expire_s) begin
                    state_d = ST_ERROR;
                end else if (bus.word_valid_i) begin
                    if (bus.word_data_i == TERM_WORD) begin
                        state_d = (state_q == ST_LOAD0) ? ST_GAP : ST_WAIT_IP;
                    end else if (cnt_q >= BANK_FULL) begin
                        // Bank already holds a full image: refuse the word.
                        state_d = ST_ERROR;
                    end else begin
                        mem_addr_d = cnt_q[MEM_AW-1:0];
                        mem_data_d = bus.word_data_i;
                        cnt_d      = cnt_q + LEN_ONE;
                        if (state_q == ST_LOAD0) begin
                            we0_d  = 1'b1;
                            len0_d = cnt_q + LEN_ONE;
                        end else begin
                            we1_d  = 1'b1;
                            len1_d = cnt_q + LEN_ONE;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_GAP: begin
                cnt_d = '0;
                if (gap_q == GAP_LAST) begin
                    state_d = ST_LOAD1;
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end
            ST_WAIT_IP: begin
                if (bus.ip_done_i) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT_IP;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase

        fill_d  = is_load(state_d);
        frst_d  = (state_d == ST_GAP);
        flash_d = (state_d == ST_LOAD0) ? FLASH_ADDR0 : FLASH_ADDR1;
        soc_d   = (state_d == ST_DONE);
        busy_d  = (state_d != ST_DONE) && (state_d != ST_ERROR);
        err_d   = (state_d == ST_ERROR);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_LOAD0;
            cnt_q      <= '0;
            gap_q      <= '0;
            len0_q     <= '0;
            len1_q     <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            we0_q      <= 1'b0;
            we1_q      <= 1'b0;
            fill_q     <= 1'b0;
            frst_q     <= 1'b0;
            soc_q      <= 1'b0;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            flash_q    <= FLASH_ADDR0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            len0_q     <= len0_d;
            len1_q     <= len1_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            we0_q      <= we0_d;
            we1_q      <= we1_d;
            fill_q     <= fill_d;
            frst_q     <= frst_d;
            soc_q      <= soc_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            flash_q    <= flash_d;
        end
    end

    assign bus.fill_o       = fill_q;
    assign bus.fetch_rst_o  = frst_q;
    assign bus.flash_addr_o = flash_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;
    assign bus.mem_we0_o    = we0_q;
    assign bus.mem_we1_o    = we1_q;
    assign bus.soc_rstn_o   = soc_q;
    assign bus.busy_o       = busy_q;
    assign bus.error_o      = err_q;
    assign bus.len0_o       = len0_q;
    assign bus.len1_o       = len1_q;
endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Bench for boot_loader_ctrl: a phase-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_boot_loader_ctrl;
    localparam int          TMO  = 64;
    localparam int          GAPN = 12;
    localparam logic [31:0] TERM = 32'hFFFF_FFFF;
    localparam logic [23:0] FA0  = 24'h030000;
    localparam logic [23:0] FA1  = 24'h050000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    boot_loader_ctrl_if bus ();

    boot_loader_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (phase level) ----------------
    string       m_ph = "LOAD0";
    int          m_n = 0, m_gap = 0, m_idle = 0;
    bit          m_started = 1'b0;
    logic        m_fill, m_frst, m_soc, m_busy, m_err, m_we0, m_we1;
    logic [23:0] m_flash;
    logic [13:0] m_maddr;
    logic [31:0] m_mdata;
    logic [14:0] m_len0, m_len1;

    always @(posedge clk) begin
        if (rst) begin
            m_started = 1'b1;
            m_ph = "LOAD0"; m_n = 0; m_gap = 0; m_idle = 0;
            m_len0 = 15'd0; m_len1 = 15'd0; m_maddr = 14'd0; m_mdata = 32'd0;
            m_we0 = 1'b0; m_we1 = 1'b0; m_fill = 1'b0; m_frst = 1'b0;
            m_soc = 1'b0; m_busy = 1'b1; m_err = 1'b0; m_flash = FA0;
        end else begin
            m_we0 = 1'b0; m_we1 = 1'b0;
            if (m_ph == "LOAD0" || m_ph == "LOAD1") begin
                if (bus.word_valid_i) begin
                    m_idle = 0;
                    if (bus.word_data_i == TERM) begin
                        if (m_ph == "LOAD0") begin m_ph = "GAP"; m_gap = 0; end
                        else m_ph = "WAIT_IP";
                    end else if (m_n >= 16384) begin
                        m_ph = "ERROR";
                    end else begin
                        m_maddr = 14'(m_n);
                        m_mdata = bus.word_data_i;
                        if (m_ph == "LOAD0") begin m_we0 = 1'b1; m_len0 = 15'(m_n + 1); end
                        else begin m_we1 = 1'b1; m_len1 = 15'(m_n + 1); end
                        m_n++;
                    end
                end else begin
                    m_idle++;
                    if (m_idle >= TMO) m_ph = "ERROR";
                end
            end else if (m_ph == "GAP") begin
                m_n = 0;
                m_gap++;
                if (m_gap >= GAPN) begin m_ph = "LOAD1"; m_idle = 0; end
            end else if (m_ph == "WAIT_IP") begin
                if (bus.ip_done_i) m_ph = "DONE";
            end
            m_fill  = (m_ph == "LOAD0") || (m_ph == "LOAD1");
            m_frst  = (m_ph == "GAP");
            m_flash = (m_ph == "LOAD0") ? FA0 : FA1;
            m_soc   = (m_ph == "DONE");
            m_busy  = !((m_ph == "DONE") || (m_ph == "ERROR"));
            m_err   = (m_ph == "ERROR");
        end
    end

    // ---------------- per-cycle compare + write scoreboard ----------------
    logic [31:0]  dmem0 [0:16383];
    logic [31:0]  dmem1 [0:16383];
    int           n_we0 = 0, n_we1 = 0, n_frst = 0;
    int           last_addr0 = -1;
    logic [106:0] exp_v, act_v;

    always @(negedge clk) begin
        if (m_started) begin
            exp_v = {m_fill, m_frst, m_flash, m_maddr, m_mdata, m_we0, m_we1,
                     m_soc, m_busy, m_err, m_len0, m_len1};
            act_v = {bus.fill_o, bus.fetch_rst_o, bus.flash_addr_o, bus.mem_addr_o,
                     bus.mem_data_o, bus.mem_we0_o, bus.mem_we1_o, bus.soc_rstn_o,
                     bus.busy_o, bus.error_o, bus.len0_o, bus.len1_o};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, act_v, exp_v);
            end
            if (bus.mem_we0_o === 1'b1) begin
                n_we0++; dmem0[bus.mem_addr_o] = bus.mem_data_o; last_addr0 = int'(bus.mem_addr_o);
            end
            if (bus.mem_we1_o === 1'b1) begin
                n_we1++; dmem1[bus.mem_addr_o] = bus.mem_data_o;
            end
            if (bus.fetch_rst_o === 1'b1) n_frst++;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.word_valid_i = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        bus.word_valid_i = 1'b1;
        bus.word_data_i  = d;
        tick(1);
        bus.word_valid_i = 1'b0;
    endtask

    int s_we0, s_we1, s_frst;

    initial begin
        bus.word_valid_i = 1'b0;
        bus.word_data_i  = 32'd0;
        bus.ip_done_i    = 1'b0;

        // ---- nominal two-image boot; ip_done high all along ----
        bus.ip_done_i = 1'b1;
        do_reset();
        chk("rst_fill", bus.fill_o, 1'b0);
        chk("rst_busy", bus.busy_o, 1'b1);
        chk("rst_soc", bus.soc_rstn_o, 1'b0);
        chk("rst_err", bus.error_o, 1'b0);
        chk("rst_frst", bus.fetch_rst_o, 1'b0);
        chk("rst_flash", bus.flash_addr_o, FA0);
        s_we0 = n_we0; s_we1 = n_we1; s_frst = n_frst;
        send(32'd1); send(32'd2); send(32'd3); send(TERM);
        send(32'h0000_1234);            // during GAP: must be ignored
        tick(13);
        chk("gap_flash", bus.flash_addr_o, FA1);
        send(32'hA5A5_0001); send(32'h5A5A_0002); send(TERM);
        tick(3);
        chk("n1_soc", bus.soc_rstn_o, 1'b1);
        chk("n1_busy", bus.busy_o, 1'b0);
        chk("n1_len0", bus.len0_o, 15'd3);
        chk("n1_len1", bus.len1_o, 15'd2);
        chk("n1_model_len0", m_len0, 15'd3);
        chk("n1_we0_cnt", n_we0 - s_we0, 3);
        chk("n1_we1_cnt", n_we1 - s_we1, 2);
        chk("n1_frst_cnt", n_frst - s_frst, GAPN);
        chk("n1_m0_0", dmem0[0], 32'd1);
        chk("n1_m0_1", dmem0[1], 32'd2);
        chk("n1_m0_2", dmem0[2], 32'd3);
        chk("n1_m1_0", dmem1[0], 32'hA5A5_0001);
        chk("n1_m1_1", dmem1[1], 32'h5A5A_0002);

        // ---- immediate terminators ----
        bus.ip_done_i = 1'b0;
        do_reset();
        s_we0 = n_we0; s_we1 = n_we1;
        send(TERM); tick(14); send(TERM); tick(2);
        bus.ip_done_i = 1'b1; tick(2);
        chk("e_len0", bus.len0_o, 15'd0);
        chk("e_len1", bus.len1_o, 15'd0);
        chk("e_writes", (n_we0 - s_we0) + (n_we1 - s_we1), 0);
        chk("e_soc", bus.soc_rstn_o, 1'b1);

        // ---- ip_done held low for 1000 cycles ----
        bus.ip_done_i = 1'b0;
        do_reset();
        send(32'd7); send(32'd8); send(TERM); tick(14);
        send(32'd9); send(TERM);
        tick(1000);
        chk("w_soc_low", bus.soc_rstn_o, 1'b0);
        chk("w_busy", bus.busy_o, 1'b1);
        bus.ip_done_i = 1'b1;
        tick(1);
        chk("w_soc_next", bus.soc_rstn_o, 1'b1);

        // ---- reset mid image1 ----
        bus.ip_done_i = 1'b0;
        do_reset();
        send(32'd11); send(TERM); tick(14);
        for (int i = 0; i < 5; i++) send(32'h100 + 32'(i));
        chk("r_len1_pre", bus.len1_o, 15'd5);
        rst = 1'b1; tick(1);
        chk("r_flash", bus.flash_addr_o, FA0);
        chk("r_len1", bus.len1_o, 15'd0);
        chk("r_addr", bus.mem_addr_o, 14'd0);
        chk("r_soc", bus.soc_rstn_o, 1'b0);
        rst = 1'b0;
        send(32'hCAFE_0001);
        chk("r_we0", bus.mem_we0_o, 1'b1);
        chk("r_waddr", bus.mem_addr_o, 14'd0);
        chk("r_wdata", bus.mem_data_o, 32'hCAFE_0001);

        // ---- timeout in LOAD1 ----
        do_reset();
        s_we0 = n_we0; s_we1 = n_we1;
        send(TERM); tick(14); tick(60);
        chk("t_err_before", bus.error_o, 1'b0);
        tick(2);
        chk("t_err", bus.error_o, 1'b1);
        chk("t_fill", bus.fill_o, 1'b0);
        send(32'd5); send(32'd6); tick(2);
        chk("t_nowrite", (n_we0 - s_we0) + (n_we1 - s_we1), 0);
        chk("t_sticky", bus.error_o, 1'b1);

        // ---- overflow of bank 0 ----
        do_reset();
        s_we0 = n_we0;
        bus.word_valid_i = 1'b1;
        for (int i = 0; i < 16385; i++) begin
            bus.word_data_i = 32'(i + 1);
            tick(1);
        end
        bus.word_valid_i = 1'b0;
        tick(2);
        chk("o_writes", n_we0 - s_we0, 16384);
        chk("o_last_addr", last_addr0, 16383);
        chk("o_last_data", dmem0[16383], 32'd16384);
        chk("o_len0", bus.len0_o, 15'd16384);
        chk("o_err", bus.error_o, 1'b1);
        chk("o_soc", bus.soc_rstn_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
